// File: rtl/pcg_stream_arbiter.sv
// Sequencer and round-robin arbiter for a 128-bit PCG generator: it holds the
// generator in reset while the seed is loaded and discards the warm-up outputs.
// After that it hands each generated word to at most one of NREQ requesters.
module pcg_stream_arbiter #(
    parameter int NREQ = 4,
    parameter int SEED_HOLD = 4,
    parameter int WARMUP = 8,
    parameter logic [127:0] DEFAULT_SEED = 128'h0123456789ABCDEF_FEDCBA9876543210
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [127:0]      seed_in,
    input  logic              reseed,
    input  logic [127:0]      prng_data,
    output logic              prng_rst,
    output logic [127:0]      prng_seedloop,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic [127:0]      rnd_out,
    output logic              rnd_valid,
    output logic              busy,
    output logic [31:0]       words_issued
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MAXC = (SEED_HOLD > WARMUP) ? SEED_HOLD : WARMUP;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SEED_LAST = CW'(SEED_HOLD - 1);
    localparam logic [CW-1:0] WARM_LAST = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [PW-1:0] PTR_INIT = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SERVE  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [PW-1:0]   ptr_reg;
    logic [127:0]    seedloop_reg;
    logic [NREQ-1:0] gnt_reg;
    logic [127:0]    rnd_out_reg;
    logic            rnd_valid_reg;
    logic [31:0]     words_issued_reg;

    logic            any_req;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;

    // Search upward from the slot after the last winner, wrapping at NREQ.
    always_comb begin
        logic found;
        int   j;
        found   = 1'b0;
        win_idx = ptr_reg;
        j       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr_reg) + k) % NREQ;
            if (!found && req[j]) begin
                found   = 1'b1;
                win_idx = PW'(j);
            end
        end
    end

    assign any_req = |req;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_SEED;
            cnt_reg          <= '0;
            ptr_reg          <= PTR_INIT;
            seedloop_reg     <= DEFAULT_SEED;
            gnt_reg          <= '0;
            rnd_out_reg      <= '0;
            rnd_valid_reg    <= 1'b0;
            words_issued_reg <= '0;
        end else if (reseed) begin
            // A reseed restarts the whole sequence but keeps the grant count.
            state_reg     <= ST_SEED;
            cnt_reg       <= '0;
            ptr_reg       <= PTR_INIT;
            seedloop_reg  <= seed_in;
            gnt_reg       <= '0;
            rnd_valid_reg <= 1'b0;
        end else begin
            gnt_reg       <= '0;
            rnd_valid_reg <= 1'b0;
            case (state_reg)
                ST_SEED: begin
                    if (cnt_reg == SEED_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= (WARMUP == 0) ? ST_SERVE : ST_WARMUP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WARMUP: begin
                    if (cnt_reg == WARM_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_SERVE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (any_req) begin
                        gnt_reg          <= win_onehot;
                        rnd_out_reg      <= prng_data;
                        rnd_valid_reg    <= 1'b1;
                        ptr_reg          <= win_idx;
                        words_issued_reg <= words_issued_reg + 32'd1;
                    end
                end
                default: begin
                    state_reg <= ST_SEED;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign prng_rst      = (state_reg == ST_SEED);
    assign busy          = (state_reg != ST_SERVE);
    assign prng_seedloop = seedloop_reg;
    assign gnt           = gnt_reg;
    assign rnd_out       = rnd_out_reg;
    assign rnd_valid     = rnd_valid_reg;
    assign words_issued  = words_issued_reg;

endmodule
